fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/core_pkg.sv | 32 +++
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, pipeline register payloads and PC alignment.
package core_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               pred_taken;
  } if_id_t;

  // Word accepted while decode was stalled, with its successor PC already resolved.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               pred_taken;
    logic [31:0]        npc;
  } skid_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears to a NOP bubble and wins over enable.
module if_id_reg
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   en,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush) begin
      q_d = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pred_taken: 1'b0};
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pred_taken: 1'b0};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, imem req/ack handshake, skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetched/redirect/stall performance counters.
//
//  state | meaning
//  FETCH | request pc_f; accepted word goes to IF/ID (or to skid if decode stalls)
//  HOLD  | word parked in skid, no request, waiting for decode to free up
//  KILL  | wrong-path request still in flight at kill_addr; drop its data on ack
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        pc_f,
  input  logic               pred_hit,
  input  logic [31:0]        pred_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               stall_d,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic [31:0]        pc_d,
  output logic               pred_taken_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt_fetched,
  output logic [CNT_W-1:0]   cnt_redirect,
  output logic [CNT_W-1:0]   cnt_stall
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  kill_addr_q, kill_addr_d;
  skid_t        skid_q, skid_d;
  logic         req_en_q, req_en_d;

  logic         accept;
  logic [31:0]  next_pc;
  logic         ifid_flush;
  logic         ifid_en;
  if_id_t       ifid_in;
  if_id_t       ifid_q;

  // req_en_q keeps the bus quiet during reset and for the first cycle out of it.
  assign imem_req  = req_en_q && (state_q != HOLD);
  assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_f_q;
  assign accept    = (state_q == FETCH) && req_en_q && imem_ack;
  assign next_pc   = pred_hit ? align_pc(pred_pc) : pc_f_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    kill_addr_d = kill_addr_q;
    skid_d      = skid_q;
    req_en_d    = 1'b1;
    ifid_flush  = 1'b0;
    ifid_en     = !stall_d;
    ifid_in     = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pred_taken: 1'b0};

    if (redirect_valid) begin
      ifid_flush = 1'b1;
      pc_f_d     = align_pc(redirect_pc);
      if (state_q == KILL) begin
        if (imem_ack) state_d = FETCH;
      end else if (imem_req && !imem_ack) begin
        state_d     = KILL;
        kill_addr_d = pc_f_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (accept) begin
            if (stall_d) begin
              skid_d  = '{instr: imem_rdata, pc: pc_f_q, pred_taken: pred_hit, npc: next_pc};
              state_d = HOLD;
            end else begin
              ifid_in = '{valid: 1'b1, instr: imem_rdata, pc: pc_f_q, pred_taken: pred_hit};
              pc_f_d  = next_pc;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            ifid_in = '{valid: 1'b1, instr: skid_q.instr, pc: skid_q.pc,
                        pred_taken: skid_q.pred_taken};
            pc_f_d  = skid_q.npc;
            state_d = FETCH;
          end
        end
        KILL: begin
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_f_q      <= RESET_PC;
      kill_addr_q <= 32'h0;
      skid_q      <= '0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      kill_addr_q <= kill_addr_d;
      skid_q      <= skid_d;
      req_en_q    <= req_en_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (ifid_flush),
    .en    (ifid_en),
    .d     (ifid_in),
    .q     (ifid_q)
  );

  assign pc_f         = pc_f_q;
  assign valid_d      = ifid_q.valid;
  assign instr_d      = ifid_q.instr;
  assign pc_d         = ifid_q.pc;
  assign pred_taken_d = ifid_q.pred_taken;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_fetched_q, cnt_fetched_d;
  logic [CNT_W-1:0] cnt_redirect_q, cnt_redirect_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  // Words dropped by a same-cycle redirect were never accepted.
  always_comb begin
    cnt_fetched_d  = cnt_fetched_q;
    cnt_redirect_d = cnt_redirect_q;
    cnt_stall_d    = cnt_stall_q;
    if (accept && !redirect_valid) cnt_fetched_d = cnt_fetched_q + 1'b1;
    if (redirect_valid)            cnt_redirect_d = cnt_redirect_q + 1'b1;
    if (stall_d)                   cnt_stall_d = cnt_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_fetched_q  <= '0;
      cnt_redirect_q <= '0;
      cnt_stall_q    <= '0;
    end else begin
      cnt_fetched_q  <= cnt_fetched_d;
      cnt_redirect_q <= cnt_redirect_d;
      cnt_stall_q    <= cnt_stall_d;
    end
  end

  assign cnt_fetched  = cnt_fetched_q;
  assign cnt_redirect = cnt_redirect_q;
  assign cnt_stall    = cnt_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_hit;
  logic [31:0] pred_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        pred_taken_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetched, cnt_redirect, cnt_stall;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_f           (pc_f),
    .pred_hit       (pred_hit),
    .pred_pc        (pred_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pred_taken_d   (pred_taken_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_fetched    (cnt_fetched),
    .cnt_redirect   (cnt_redirect),
    .cnt_stall      (cnt_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predictor and memory contents
  logic        pt_hit[32];
  logic [31:0] pt_tgt[32];
  int          lat_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C00_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Reference model: architectural fetch PC, bus activity and decode-visible word
  logic [31:0] m_pc, m_kill_addr;
  logic        m_live, m_held, m_killing;
  logic [31:0] h_instr, h_pc, h_npc;
  logic        h_pred;
  logic        m_v, m_t;
  logic [31:0] m_i, m_p;

  task automatic model_bubble();
    m_v = 1'b0; m_i = 32'h0; m_p = 32'h0; m_t = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_kill_addr = 32'h0;
    m_live = 1'b0; m_held = 1'b0; m_killing = 1'b0;
    model_bubble();
    lat_left = $urandom_range(0, 2);
  endtask

  // Applies one clock edge using the inputs that were driven during the cycle.
  task automatic model_step();
    logic [31:0] npc;
    logic        on_bus;
    on_bus = m_live && !m_held;
    if (redirect_valid) begin
      model_bubble();
      if (m_killing) begin
        if (imem_ack) m_killing = 1'b0;
      end else if (on_bus && !imem_ack) begin
        m_killing   = 1'b1;
        m_kill_addr = m_pc;
      end
      m_held = 1'b0;
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
    end else if (m_killing) begin
      if (imem_ack) m_killing = 1'b0;
      if (!stall_d) model_bubble();
    end else if (m_held) begin
      if (!stall_d) begin
        m_v = 1'b1; m_i = h_instr; m_p = h_pc; m_t = h_pred;
        m_pc   = h_npc;
        m_held = 1'b0;
      end
    end else if (m_live && imem_ack) begin
      npc = pred_hit ? (pred_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
      if (stall_d) begin
        h_instr = imem_rdata; h_pc = m_pc; h_pred = pred_hit; h_npc = npc;
        m_held  = 1'b1;
      end else begin
        m_v = 1'b1; m_i = imem_rdata; m_p = m_pc; m_t = pred_hit;
        m_pc = npc;
      end
    end else if (!stall_d) begin
      model_bubble();
    end
    m_live = 1'b1;
  endtask

  task automatic compare_all();
    check_eq("imem_req", 32'(imem_req), 32'(m_live && !m_held));
    if (m_live && !m_held) check_eq("imem_addr", imem_addr, m_killing ? m_kill_addr : m_pc);
    check_eq("pc_f", pc_f, m_pc);
    check_eq("valid_d", 32'(valid_d), 32'(m_v));
    check_eq("instr_d", instr_d, m_i);
    if (m_v) begin
      check_eq("pc_d", pc_d, m_p);
      check_eq("pred_taken_d", 32'(pred_taken_d), 32'(m_t));
    end
  endtask

  task automatic drive_inputs(input bit force_wrap, input bit force_stall);
    stall_d        = force_stall || ($urandom_range(0, 3) == 0);
    redirect_valid = !force_stall && ($urandom_range(0, 9) == 0);
    redirect_pc    = $urandom & 32'h0000_03FF;
    if (force_wrap) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
    end
    pred_hit = pt_hit[pc_f[6:2]];
    pred_pc  = pt_tgt[pc_f[6:2]];
    imem_ack = 1'b0;
    if (imem_req) begin
      if (lat_left == 0) begin
        imem_ack = 1'b1;
        lat_left = $urandom_range(0, 2);
      end else begin
        lat_left--;
      end
    end
    if (m_killing && imem_ack) redirect_valid = 1'b0;
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
  endtask

  task automatic run_cycles(input int n, input int wrap_at);
    for (int i = 0; i < n; i++) begin
      drive_inputs(i == wrap_at, 1'b0);
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      pt_hit[k] = ($urandom_range(0, 4) == 0);
      pt_tgt[k] = $urandom & 32'h0000_03FF;
    end
    pt_hit[31] = 1'b0;  // lets the fetch at 0xFFFF_FFFC fall through and wrap to 0

    rst_n = 1'b0;
    pred_hit = 1'b0; pred_pc = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    stall_d = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    run_cycles(600, 150);

    // Park a word in the skid buffer, then pull reset mid-cycle
    for (int k = 0; k < 50 && !m_held; k++) begin
      drive_inputs(1'b0, 1'b1);
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
    check_eq("hold_reached", 32'(m_held), 32'd1);
    #3;
    rst_n = 1'b0;
    redirect_valid = 1'b0; imem_ack = 1'b0; stall_d = 1'b0;
    #1;
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_pc_f", pc_f, 32'h0);
    check_eq("rst_valid_d", 32'(valid_d), 32'd0);
    check_eq("rst_instr_d", instr_d, 32'h0);
    check_eq("rst_pc_d", pc_d, 32'h0);
    check_eq("rst_pred_taken_d", 32'(pred_taken_d), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_cnt_fetched", cnt_fetched, 32'h0);
    check_eq("rst_cnt_redirect", cnt_redirect, 32'h0);
    check_eq("rst_cnt_stall", cnt_stall, 32'h0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    run_cycles(200, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
